// File: rtl/avg_line_raster_if.sv
// Handshake bundle between the line-register queue, the rasterizer and the framebuffer write port.
// The master side is the rasterizer: it pops the queue and issues pixel writes.
interface avg_line_raster_if #(
    parameter int AW = 19
);
    logic signed [10:0] qStartX;
    logic signed [10:0] qStartY;
    logic signed [10:0] qEndX;
    logic signed [10:0] qEndY;
    logic [2:0]         qColor;
    logic               qEmpty;
    logic               qRead;
    logic [AW-1:0]      fbAddr;
    logic [2:0]         fbColor;
    logic               fbWe;
    logic               fbReady;

    modport master (
        input  qStartX, qStartY, qEndX, qEndY, qColor, qEmpty, fbReady,
        output qRead, fbAddr, fbColor, fbWe
    );

    modport slave (
        output qStartX, qStartY, qEndX, qEndY, qColor, qEmpty, fbReady,
        input  qRead, fbAddr, fbColor, fbWe
    );
endinterface

// File: rtl/avg_line_raster.sv
// Bresenham line rasterizer: pops one segment from the line queue and emits one
// framebuffer pixel write per cycle, silently dropping pixels that fall off screen.
module avg_line_raster #(
    parameter int XMAX = 640,
    parameter int YMAX = 480,
    parameter int AW   = 19
) (
    input  logic                 clk,
    input  logic                 rst_b,
    avg_line_raster_if.master    bus,
    output logic                 busy,
    output logic [15:0]          linesDone
);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

    localparam logic signed [11:0] HALF_X = 12'(XMAX / 2);
    localparam logic signed [11:0] HALF_Y = 12'(YMAX / 2);
    localparam logic signed [11:0] XMAX_S = 12'(XMAX);
    localparam logic signed [11:0] YMAX_S = 12'(YMAX);

    state_t state, stateNext;

    logic signed [10:0] x0, y0, x1, y1;
    logic [2:0]         color;
    logic signed [11:0] dx, dy, sx, sy;
    logic signed [11:0] curX, curY;
    logic signed [12:0] err;

    logic signed [11:0] xDiff, yDiff, dxSetup, dySetup;
    logic signed [11:0] px, py;
    logic               onScreen, atEnd, advance;
    logic [AW-1:0]      pixAddr;
    logic signed [13:0] e2, dx14, dy14;
    logic               stepX, stepY;
    logic signed [12:0] addX, addY;

    // Segment geometry, screen mapping and the Bresenham step decision for the current pixel.
    always_comb begin
        xDiff   = 12'(x1) - 12'(x0);
        yDiff   = 12'(y1) - 12'(y0);
        dxSetup = (xDiff < 0) ? -xDiff : xDiff;
        dySetup = (yDiff < 0) ? yDiff : -yDiff;

        px       = curX + HALF_X;
        py       = HALF_Y - curY;
        onScreen = (px >= 12'sd0) && (px < XMAX_S) && (py >= 12'sd0) && (py < YMAX_S);
        pixAddr  = AW'($unsigned(py)) * AW'(XMAX) + AW'($unsigned(px));
        atEnd    = (curX == 12'(x1)) && (curY == 12'(y1));
        advance  = !onScreen || bus.fbReady;

        e2    = {err, 1'b0};
        dx14  = 14'(dx);
        dy14  = 14'(dy);
        stepX = (e2 >= dy14);
        stepY = (e2 <= dx14);
        addX  = stepX ? 13'(dy) : 13'sd0;
        addY  = stepY ? 13'(dx) : 13'sd0;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Queue pop is gated by reset so the strobe is low while the block is held in reset.
    always_comb begin
        stateNext   = state;
        bus.qRead   = 1'b0;
        bus.fbWe    = 1'b0;
        bus.fbAddr  = '0;
        bus.fbColor = 3'd0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (!bus.qEmpty && rst_b) begin
                    bus.qRead = 1'b1;
                    stateNext = SETUP;
                end
            end
            SETUP: begin
                stateNext = DRAW;
            end
            DRAW: begin
                bus.fbWe    = onScreen;
                bus.fbAddr  = pixAddr;
                bus.fbColor = color;
                if (advance && atEnd) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            x0        <= '0;
            y0        <= '0;
            x1        <= '0;
            y1        <= '0;
            color     <= '0;
            dx        <= '0;
            dy        <= '0;
            sx        <= '0;
            sy        <= '0;
            curX      <= '0;
            curY      <= '0;
            err       <= '0;
            linesDone <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.qEmpty) begin
                        x0    <= bus.qStartX;
                        y0    <= bus.qStartY;
                        x1    <= bus.qEndX;
                        y1    <= bus.qEndY;
                        color <= bus.qColor;
                    end
                end
                SETUP: begin
                    dx   <= dxSetup;
                    dy   <= dySetup;
                    sx   <= (x0 < x1) ? 12'sd1 : -12'sd1;
                    sy   <= (y0 < y1) ? 12'sd1 : -12'sd1;
                    err  <= 13'(dxSetup) + 13'(dySetup);
                    curX <= 12'(x0);
                    curY <= 12'(y0);
                end
                DRAW: begin
                    if (advance) begin
                        if (atEnd) begin
                            linesDone <= linesDone + 16'd1;
                        end else begin
                            // Both axis steps are decided from the same e2 and may land together.
                            err <= err + addX + addY;
                            if (stepX) curX <= curX + sx;
                            if (stepY) curY <= curY + sy;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/avg_line_raster.md
Name: avg_line_raster

Overview:
- Rasterizer directly downstream of the AVG line-register queue.
- Pops one line segment at a time: start/end coordinates plus 3-bit color.
- Walks the segment with integer Bresenham stepping and emits one framebuffer pixel write per cycle.
- Pixels outside the screen are dropped. Sits between lineRegQueue and the framebuffer write port.

Parameters:
- XMAX, 640, screen width in pixels.
- YMAX, 480, screen height in pixels.
- AW, 19, framebuffer address width; must satisfy 2^AW >= XMAX*YMAX.

Ports:
- clk  input  1  system clock.
- rst_b  input  1  asynchronous active-low reset.
- qStartX  input  11  head-of-queue start X, two's complement.
- qStartY  input  11  head-of-queue start Y, two's complement.
- qEndX  input  11  head-of-queue end X, two's complement.
- qEndY  input  11  head-of-queue end Y, two's complement.
- qColor  input  3  head-of-queue color.
- qEmpty  input  1  queue empty flag.
- qRead  output  1  one-cycle pop strobe to queue.
- fbAddr  output  AW  pixel address, py*XMAX+px.
- fbColor  output  3  pixel color.
- fbWe  output  1  pixel write valid.
- fbReady  input  1  framebuffer accepts write this cycle.
- busy  output  1  high in any state other than IDLE.
- linesDone  output  16  count of completed segments, wraps at 65535->0.

Behaviour:
- Reset (async, rst_b low): state=IDLE; qRead=0, fbWe=0, fbAddr=0, fbColor=0, busy=0, linesDone=0; all internal registers cleared. Reset mid-line abandons the segment; no further writes for it.
- Coordinate map: signed coordinate (x,y) -> screen px = x + XMAX/2, py = YMAX/2 - y. Compute at 12-bit signed width.
- On-screen iff 0<=px<XMAX and 0<=py<YMAX.
- IDLE:
  - If !qEmpty: qRead=1 for exactly this cycle. Latch all q* inputs this same cycle; queue head is valid combinationally before the pop. Next state SETUP.
  - Else stay, qRead=0.
- SETUP (1 cycle):
  - dx = |x1-x0|, dy = -|y1-y0|, both 12-bit signed.
  - sx = +1 if x0<x1 else -1; sy = +1 if y0<y1 else -1.
  - err = dx+dy at 13-bit signed.
  - cur = (x0,y0). Next state DRAW.
- DRAW, each cycle:
  - Present pixel cur: fbWe = on-screen(cur), with fbAddr/fbColor driven combinationally from cur.
  - Advance when (!onScreen || fbReady). If on-screen and !fbReady, hold cur, err, fbWe=1 and address stable.
  - On advance, if cur==(x1,y1): linesDone++, next state IDLE.
  - Otherwise: e2 = 2*err. If e2>=dy: err+=dy, x+=sx. If e2<=dx: err+=dx, y+=sy. Both updates apply in the same cycle when both hold.
- Throughput: max(|dx|,|dy|)+1 DRAW cycles per line with fbReady=1.
- Latency: qRead cycle T, SETUP T+1, first pixel write presented T+2.
- Back-to-back lines: IDLE costs one cycle between segments. No pop occurs while busy.
- Zero-length line (start==end): exactly one pixel, then IDLE.
- Fully off-screen line: still walked, with zero fbWe pulses; linesDone still increments.
- fbWe is never asserted outside DRAW. qRead is never asserted when qEmpty=1.

Test Plan:
- Horizontal, fbReady=1: queue (0,0)->(3,0), color 5 -> qRead one cycle; fbWe on 4 consecutive cycles starting 2 cycles after qRead; fbAddr=153920,153921,153922,153923; fbColor=5; linesDone=1; busy low afterward.
- Steep line: (0,0)->(1,3) -> 4 writes at screen (320,240),(320,239),(321,238),(321,237); addrs 153920,153280,152641,152001.
- Backpressure: horizontal case with fbReady low for 3 cycles on the second pixel -> fbAddr holds 153921 with fbWe=1 through the stall; total writes still 4 with no duplicates or skips.
- Clipping: (318,0)->(322,0) -> 5 DRAW cycles; fbWe only for px=638,639 (addrs 154238,154239); linesDone=1.
- Zero-length line and empty queue: (−320,239)->(−320,239) -> single write at addr 640 (px=0, py=1); then with qEmpty=1 for 20 cycles, qRead stays 0 and busy stays 0.
- Reset mid-line: assert rst_b low during DRAW of (0,0)->(100,0) -> fbWe, qRead, busy, linesDone all 0 immediately; after release, no writes until a new queue entry arrives.
